// File: rtl/nibble_serial_add_ctrl.sv
// rtl/nibble_serial_add_ctrl.sv - wide add/subtract sequenced through one shared 4-bit adder slice
module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 op_sub,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 cin,
    output logic [3:0]           add_a,
    output logic [3:0]           add_b,
    output logic                 add_ci,
    input  logic [3:0]           add_s,
    input  logic                 add_co,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout,
    output logic                 ovf
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [W-1:0]     a_reg;
    logic [W-1:0]     b_reg;
    logic             carry;
    logic [IDX_W-1:0] idx;
    logic             last;

    assign last = (idx == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The slice inputs are forced to zero outside RUN so the shared adder stays quiet.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        add_a     = 4'h0;
        add_b     = 4'h0;
        add_ci    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy   = 1'b1;
                add_a  = a_reg[{idx, 2'b00} +: 4];
                add_b  = b_reg[{idx, 2'b00} +: 4];
                add_ci = carry;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Subtraction is A + ~B + 1, so b_reg holds the already-inverted operand.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= a;
                        b_reg <= op_sub ? ~b : b;
                        carry <= op_sub ? 1'b1 : cin;
                        idx   <= '0;
                        sum   <= '0;
                    end
                end
                RUN: begin
                    sum[{idx, 2'b00} +: 4] <= add_s;
                    carry                  <= add_co;
                    if (last) begin
                        idx  <= '0;
                        cout <= add_co;
                        // add_s[3] is the result MSB being written on this same edge.
                        ovf  <= (a_reg[W-1] == b_reg[W-1]) && (add_s[3] != a_reg[W-1]);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb/tb_nibble_serial_add_ctrl.sv - directed self-checking bench for nibble_serial_add_ctrl
module tb_nibble_serial_add_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        op_sub;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [3:0]  add_a;
    logic [3:0]  add_b;
    logic        add_ci;
    logic [3:0]  add_s;
    logic        add_co;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign {add_co, add_s} = 5'(add_a) + 5'(add_b) + 5'(add_ci);

    nibble_serial_add_ctrl #(.NIBBLES(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op_sub (op_sub),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .add_a  (add_a),
        .add_b  (add_b),
        .add_ci (add_ci),
        .add_s  (add_s),
        .add_co (add_co),
        .busy   (busy),
        .done   (done),
        .sum    (sum),
        .cout   (cout),
        .ovf    (ovf)
    );

    // Issues one operation and waits (bounded) for done; returns at the negedge of the done cycle.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic tsub,
                          input logic tcin, input int glitch_at, output int lat,
                          output int busy_cnt, output logic [15:0] seq_a, output logic [3:0] seq_ci);
        @(negedge clk);
        a = ta; b = tb; op_sub = tsub; cin = tcin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1; busy_cnt = 0; seq_a = '0; seq_ci = '0;
        while (!done && lat < 20) begin
            if (busy) busy_cnt++;
            seq_a  = {add_a, seq_a[15:4]};
            seq_ci = {add_ci, seq_ci[3:1]};
            if (lat == glitch_at) begin
                start = 1'b1; a = 16'hAAAA; b = 16'h5555; op_sub = ~tsub; cin = ~tcin;
            end
            @(negedge clk);
            start = 1'b0;
            lat++;
        end
        if (busy) busy_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op_sub = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, sum, cout, ovf, add_a, add_b, add_ci} !== 30'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", {busy, done, sum, cout, ovf, add_a, add_b, add_ci});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_add();
        int lat; int bc; logic [15:0] sa; logic [3:0] sc;
        run_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, 0, lat, bc, sa, sc);
        checks++;
        if (lat !== 5) begin failures++; $display("FAIL add1_latency got=%0d exp=5", lat); end
        checks++;
        if (bc !== 5) begin failures++; $display("FAIL add1_busy_cycles got=%0d exp=5", bc); end
        checks++;
        if (sa !== 16'h1234) begin failures++; $display("FAIL add1_add_a_seq got=%h exp=1234", sa); end
        checks++;
        if ({sum, cout, ovf} !== {16'h2233, 1'b0, 1'b0}) begin
            failures++; $display("FAIL add1_result got=%h/%b/%b exp=2233/0/0", sum, cout, ovf);
        end
        @(negedge clk);
        checks++;
        if ({busy, done, sum} !== {1'b0, 1'b0, 16'h2233}) begin
            failures++; $display("FAIL add1_hold got=%b/%b/%h exp=0/0/2233", busy, done, sum);
        end
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, lat, bc, sa, sc);
        checks++;
        if (sc !== 4'b1110) begin failures++; $display("FAIL add2_ci_seq got=%b exp=1110", sc); end
        checks++;
        if ({sum, cout, ovf} !== {16'h0000, 1'b1, 1'b0}) begin
            failures++; $display("FAIL add2_result got=%h/%b/%b exp=0000/1/0", sum, cout, ovf);
        end
        run_op(16'h0000, 16'h0000, 1'b0, 1'b1, 0, lat, bc, sa, sc);
        checks++;
        if ({sum, cout, ovf} !== {16'h0001, 1'b0, 1'b0}) begin
            failures++; $display("FAIL add_cin_result got=%h/%b/%b exp=0001/0/0", sum, cout, ovf);
        end
    endtask

    task automatic test_sub();
        int lat; int bc; logic [15:0] sa; logic [3:0] sc;
        run_op(16'h0005, 16'h0007, 1'b1, 1'b0, 0, lat, bc, sa, sc);
        checks++;
        if ({sum, cout, ovf} !== {16'hFFFE, 1'b0, 1'b0}) begin
            failures++; $display("FAIL sub1_result got=%h/%b/%b exp=fffe/0/0", sum, cout, ovf);
        end
        run_op(16'h8000, 16'h0001, 1'b1, 1'b1, 0, lat, bc, sa, sc);
        checks++;
        if ({sum, cout, ovf} !== {16'h7FFF, 1'b1, 1'b1}) begin
            failures++; $display("FAIL sub2_result got=%h/%b/%b exp=7fff/1/1", sum, cout, ovf);
        end
    endtask

    task automatic test_ovf();
        int lat; int bc; logic [15:0] sa; logic [3:0] sc;
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, lat, bc, sa, sc);
        checks++;
        if ({sum, cout, ovf} !== {16'h8000, 1'b0, 1'b1}) begin
            failures++; $display("FAIL add_ovf_result got=%h/%b/%b exp=8000/0/1", sum, cout, ovf);
        end
    endtask

    task automatic test_ignore_start();
        int lat; int bc; logic [15:0] sa; logic [3:0] sc;
        run_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, 2, lat, bc, sa, sc);
        checks++;
        if (lat !== 5) begin failures++; $display("FAIL ignore_latency got=%0d exp=5", lat); end
        checks++;
        if ({sum, cout, ovf} !== {16'h2233, 1'b0, 1'b0}) begin
            failures++; $display("FAIL ignore_result got=%h/%b/%b exp=2233/0/0", sum, cout, ovf);
        end
        // start seen only during the DONE cycle must not launch an operation
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL start_in_done got=%b exp=0", busy); end
    endtask

    task automatic test_back_to_back();
        int lat; int bc; logic [15:0] sa; logic [3:0] sc;
        run_op(16'h1111, 16'h2222, 1'b0, 1'b0, 0, lat, bc, sa, sc);
        run_op(16'h0100, 16'h0001, 1'b1, 1'b0, 0, lat, bc, sa, sc);
        checks++;
        if (lat !== 5) begin failures++; $display("FAIL b2b_latency got=%0d exp=5", lat); end
        checks++;
        if ({sum, cout, ovf} !== {16'h00FF, 1'b1, 1'b0}) begin
            failures++; $display("FAIL b2b_result got=%h/%b/%b exp=00ff/1/0", sum, cout, ovf);
        end
    endtask

    task automatic test_rst_mid();
        int lat; int bc; logic [15:0] sa; logic [3:0] sc;
        int saw_done;
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, lat, bc, sa, sc);
        @(negedge clk);
        a = 16'h1234; b = 16'h0FFF; op_sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, sum, cout, ovf, add_a, add_b, add_ci} !== 30'h0) begin
            failures++;
            $display("FAIL rst_mid_outputs got=%h exp=0", {busy, done, sum, cout, ovf, add_a, add_b, add_ci});
        end
        saw_done = 0;
        @(negedge clk);
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        checks++;
        if (saw_done !== 0) begin failures++; $display("FAIL rst_mid_no_done got=%0d exp=0", saw_done); end
        run_op(16'h0005, 16'h0007, 1'b0, 1'b0, 0, lat, bc, sa, sc);
        checks++;
        if ({lat, sum, cout, ovf} !== {32'd5, 16'h000C, 1'b0, 1'b0}) begin
            failures++; $display("FAIL rst_recover got=%0d/%h/%b/%b exp=5/000c/0/0", lat, sum, cout, ovf);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_ovf();
        test_ignore_start();
        test_back_to_back();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
